seg_scan_decoder: RTL
=====================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter N_DIGITS, default 2, number of multiplexed digits scanned.
REQ-002 SHALL have parameter SETTLE, default 4, consecutive stable-strobe cycles before one digit is sampled (range 1..255).
REQ-003 SHALL have port i_clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_RSTn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_SEG, input, 8, segment bus {dp,g,f,e,d,c,b,a}, active-low (0 = segment ON).
REQ-006 SHALL have port i_DIG, input, N_DIGITS, digit strobe, active-high, one-hot when valid.
REQ-007 SHALL have port o_num, output, 4*N_DIGITS, decoded nibbles, digit k in bits [4k+3:4k].
REQ-008 SHALL have port o_DP, output, N_DIGITS, decimal-point state per digit (1 = dp bus bit high).
REQ-009 SHALL have port o_bad, output, N_DIGITS, per-digit flag for a pattern outside the 16-entry table (dash included).
REQ-010 SHALL have port o_dec, output, 8, binary value 10*digit1 + digit0.
REQ-011 SHALL have port o_isdec, output, 1, high when digit0 and digit1 are both 0..9 and not bad.
REQ-012 SHALL have port o_valid, output, 1, one-cycle pulse marking an output update.

Function
REQ-013 Decode table (i_SEG[6:0] -> nibble) SHALL be: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
REQ-014 Any other pattern SHALL decode to nibble 0 and set that digit's bad bit.
REQ-015 FSM SHALL have states IDLE, SETTLE, CAPTURE, CHECK.
REQ-016 IDLE -> SETTLE when i_DIG is one-hot; settle counter loaded to 1 and strobe value registered.
REQ-017 In SETTLE, the counter SHALL increment each cycle while i_DIG and i_SEG equal the registered values; any change SHALL reload the counter to 1 with the new values.
REQ-018 When the counter reaches SETTLE, the FSM SHALL go to CAPTURE; with SETTLE=1 the first one-hot cycle qualifies.
REQ-019 CAPTURE SHALL write the decoded nibble, dp and bad bit into the candidate slot of the strobed digit and set that slot's bit in the capture mask.
REQ-020 A digit captured again before the mask is full SHALL overwrite its slot; the mask is unchanged.
REQ-021 A zero or multi-hot i_DIG in any state other than CHECK SHALL return the FSM to IDLE; the capture mask is kept.
REQ-022 After CAPTURE, the FSM SHALL go to CHECK if the mask is full, else to IDLE.
REQ-023 When a slot is captured, the FSM SHALL wait in IDLE until i_DIG differs from that slot's strobe.
REQ-024 CHECK: if the candidate frame equals the previous-candidate frame, o_num/o_DP/o_bad/o_dec/o_isdec SHALL update and o_valid SHALL pulse.
REQ-025 In every CHECK, the candidate SHALL be copied to previous-candidate and the mask cleared.
REQ-026 o_valid SHALL be high exactly the one cycle after the CHECK edge.
REQ-027 Outputs SHALL hold between updates.
REQ-028 o_dec SHALL be 8'd0 whenever o_isdec is 0; max value 99.
REQ-029 For N_DIGITS=1, digit1 SHALL be treated as 0 in o_dec/o_isdec.

Reset
REQ-030 Asserting i_RSTn low SHALL immediately clear all outputs to 0, the FSM to IDLE, the counter and mask to 0, and the previous-candidate frame to an invalid marker that matches no frame.
REQ-031 A reset mid-frame SHALL discard partial captures; the first o_valid after reset requires two full matching frames.

Verification
REQ-032 Scan "25" (digit1 i_SEG=8'b10100100, digit0 8'b10010010), SETTLE=4, each strobe held 8 cycles, two frames -> one o_valid, o_num=8'h25, o_dec=8'd25, o_isdec=1, o_DP=2'b11, o_bad=0.
REQ-033 Frame 1 "25", frame 2 "26" (digit0 8'b10000010) -> no o_valid; frame 3 "26" -> o_valid, o_num=8'h26.
REQ-034 Digit0 pattern 8'b10111111 (dash) in two frames -> o_bad=2'b01, o_isdec=0, o_dec=0, o_valid pulses.
REQ-035 Strobe held only 3 cycles with SETTLE=4, or i_DIG=2'b11 -> no capture, outputs unchanged.
REQ-036 i_RSTn low during the second frame of "25", then two clean frames -> outputs 0 during reset, one o_valid after the second post-reset frame.
REQ-037 Digit0 with dp bit 0 (8'b00010010) -> o_DP[0]=0, nibble 5.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment display scanner: settles each strobed digit, decodes it into a
// candidate frame, and publishes the frame only after two identical consecutive frames.
module seg_scan_decoder #(
  parameter int N_DIGITS = 2,
  parameter int SETTLE   = 4
) (
  input  logic                  i_clock,
  input  logic                  i_RSTn,
  input  logic [7:0]            i_SEG,
  input  logic [N_DIGITS-1:0]   i_DIG,
  output logic [4*N_DIGITS-1:0] o_num,
  output logic [N_DIGITS-1:0]   o_DP,
  output logic [N_DIGITS-1:0]   o_bad,
  output logic [7:0]            o_dec,
  output logic                  o_isdec,
  output logic                  o_valid
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_CHECK   = 2'd3;

  localparam logic [7:0]          SETTLE_C = 8'(SETTLE);
  localparam logic [N_DIGITS-1:0] ZERO_D   = {N_DIGITS{1'b0}};
  localparam logic [N_DIGITS-1:0] FULL_D   = {N_DIGITS{1'b1}};

  // Returns {bad, nibble}; unknown patterns (dash included) decode to 0 and flag bad.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: seg_decode = 5'h00;
      7'b1111001: seg_decode = 5'h01;
      7'b0100100: seg_decode = 5'h02;
      7'b0110000: seg_decode = 5'h03;
      7'b0011001: seg_decode = 5'h04;
      7'b0010010: seg_decode = 5'h05;
      7'b0000010: seg_decode = 5'h06;
      7'b1111000: seg_decode = 5'h07;
      7'b0000000: seg_decode = 5'h08;
      7'b0010000: seg_decode = 5'h09;
      7'b0001000: seg_decode = 5'h0A;
      7'b0000011: seg_decode = 5'h0B;
      7'b1000110: seg_decode = 5'h0C;
      7'b0100001: seg_decode = 5'h0D;
      7'b0000110: seg_decode = 5'h0E;
      7'b0001110: seg_decode = 5'h0F;
      default:    seg_decode = 5'h10;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [N_DIGITS-1:0] v);
    is_onehot = (v != ZERO_D) && ((v & (v - 1'b1)) == ZERO_D);
  endfunction

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [N_DIGITS-1:0]   dig_q, dig_d;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   mask_q, mask_d;
  logic                  wait_q, wait_d;
  logic [N_DIGITS-1:0]   last_dig_q, last_dig_d;
  logic [4*N_DIGITS-1:0] cand_num_q, cand_num_d;
  logic [N_DIGITS-1:0]   cand_dp_q, cand_dp_d;
  logic [N_DIGITS-1:0]   cand_bad_q, cand_bad_d;
  logic                  prev_ok_q, prev_ok_d;
  logic [4*N_DIGITS-1:0] prev_num_q, prev_num_d;
  logic [N_DIGITS-1:0]   prev_dp_q, prev_dp_d;
  logic [N_DIGITS-1:0]   prev_bad_q, prev_bad_d;
  logic [4*N_DIGITS-1:0] num_q, num_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [N_DIGITS-1:0]   bad_q, bad_d;
  logic [7:0]            dec_q, dec_d;
  logic                  isdec_q, isdec_d;
  logic                  valid_q, valid_d;

  logic                  dig_ok_s;
  logic [4:0]            decoded_s;
  logic [4*N_DIGITS+3:0] num_pad_s;
  logic [N_DIGITS:0]     bad_pad_s;
  logic [3:0]            d0_s, d1_s;
  logic                  isdec_s;
  logic [7:0]            dec_s;
  logic                  frame_match_s;

  assign dig_ok_s  = is_onehot(i_DIG);
  assign decoded_s = seg_decode(seg_q[6:0]);

  // Zero-padding above the top digit makes digit1 read as 0 when only one digit exists.
  assign num_pad_s     = {4'd0, cand_num_q};
  assign bad_pad_s     = {1'b0, cand_bad_q};
  assign d0_s          = num_pad_s[3:0];
  assign d1_s          = num_pad_s[7:4];
  assign isdec_s       = (d0_s <= 4'd9) && !bad_pad_s[0] && (d1_s <= 4'd9) && !bad_pad_s[1];
  assign dec_s         = isdec_s ? (({4'd0, d1_s} * 8'd10) + {4'd0, d0_s}) : 8'd0;
  assign frame_match_s = prev_ok_q && (cand_num_q == prev_num_q) &&
                         (cand_dp_q == prev_dp_q) && (cand_bad_q == prev_bad_q);

  // Next-state logic for the scan FSM, candidate/previous frames and published outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dig_d      = dig_q;
    seg_d      = seg_q;
    mask_d     = mask_q;
    wait_d     = wait_q;
    last_dig_d = last_dig_q;
    cand_num_d = cand_num_q;
    cand_dp_d  = cand_dp_q;
    cand_bad_d = cand_bad_q;
    prev_ok_d  = prev_ok_q;
    prev_num_d = prev_num_q;
    prev_dp_d  = prev_dp_q;
    prev_bad_d = prev_bad_q;
    num_d      = num_q;
    dp_d       = dp_q;
    bad_d      = bad_q;
    dec_d      = dec_q;
    isdec_d    = isdec_q;
    valid_d    = 1'b0;

    if (i_DIG != last_dig_q) begin
      wait_d = 1'b0;
    end else begin
      wait_d = wait_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (dig_ok_s && !(wait_q && (i_DIG == last_dig_q))) begin
          cnt_d   = 8'd1;
          dig_d   = i_DIG;
          seg_d   = i_SEG;
          state_d = (SETTLE_C == 8'd1) ? ST_CAPTURE : ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!dig_ok_s) begin
          state_d = ST_IDLE;
        end else if ((i_DIG == dig_q) && (i_SEG == seg_q)) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = ((cnt_q + 8'd1) >= SETTLE_C) ? ST_CAPTURE : ST_SETTLE;
        end else begin
          cnt_d   = 8'd1;
          dig_d   = i_DIG;
          seg_d   = i_SEG;
          state_d = (SETTLE_C == 8'd1) ? ST_CAPTURE : ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        if (!dig_ok_s) begin
          state_d = ST_IDLE;
        end else begin
          for (int k = 0; k < N_DIGITS; k++) begin
            if (dig_q[k]) begin
              cand_num_d[4*k +: 4] = decoded_s[3:0];
              cand_dp_d[k]         = seg_q[7];
              cand_bad_d[k]        = decoded_s[4];
            end else begin
              cand_dp_d[k] = cand_dp_q[k];
            end
          end
          mask_d     = mask_q | dig_q;
          wait_d     = 1'b1;
          last_dig_d = dig_q;
          state_d    = ((mask_q | dig_q) == FULL_D) ? ST_CHECK : ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (frame_match_s) begin
          num_d   = cand_num_q;
          dp_d    = cand_dp_q;
          bad_d   = cand_bad_q;
          dec_d   = dec_s;
          isdec_d = isdec_s;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
        prev_ok_d  = 1'b1;
        prev_num_d = cand_num_q;
        prev_dp_d  = cand_dp_q;
        prev_bad_d = cand_bad_q;
        mask_d     = ZERO_D;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset marks the previous frame invalid so it matches nothing.
  always_ff @(posedge i_clock or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      dig_q      <= ZERO_D;
      seg_q      <= 8'd0;
      mask_q     <= ZERO_D;
      wait_q     <= 1'b0;
      last_dig_q <= ZERO_D;
      cand_num_q <= {(4*N_DIGITS){1'b0}};
      cand_dp_q  <= ZERO_D;
      cand_bad_q <= ZERO_D;
      prev_ok_q  <= 1'b0;
      prev_num_q <= {(4*N_DIGITS){1'b0}};
      prev_dp_q  <= ZERO_D;
      prev_bad_q <= ZERO_D;
      num_q      <= {(4*N_DIGITS){1'b0}};
      dp_q       <= ZERO_D;
      bad_q      <= ZERO_D;
      dec_q      <= 8'd0;
      isdec_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
      mask_q     <= mask_d;
      wait_q     <= wait_d;
      last_dig_q <= last_dig_d;
      cand_num_q <= cand_num_d;
      cand_dp_q  <= cand_dp_d;
      cand_bad_q <= cand_bad_d;
      prev_ok_q  <= prev_ok_d;
      prev_num_q <= prev_num_d;
      prev_dp_q  <= prev_dp_d;
      prev_bad_q <= prev_bad_d;
      num_q      <= num_d;
      dp_q       <= dp_d;
      bad_q      <= bad_d;
      dec_q      <= dec_d;
      isdec_q    <= isdec_d;
      valid_q    <= valid_d;
    end
  end

  assign o_num   = num_q;
  assign o_DP    = dp_q;
  assign o_bad   = bad_q;
  assign o_dec   = dec_q;
  assign o_isdec = isdec_q;
  assign o_valid = valid_q;

endmodule
